// File: rtl/uart_rx_framer_if.sv
// rtl/uart_rx_framer_if.sv - word-in / payload-out bundle for uart_rx_framer
//
// Carries the inbound UART word strobe and the outbound payload stream.
//   s_valid, s_data         : word strobe from the UART receiver (no ready)
//   m_valid, m_ready,
//   m_data, m_last          : payload stream to the downstream consumer
// Modports:
//   master : the side that feeds words and consumes payload (receiver + sink)
//   slave  : the framer itself
interface uart_rx_framer_if #(
  parameter int W_IN = 16
);
  logic            s_valid;
  logic [W_IN-1:0] s_data;
  logic            m_valid;
  logic            m_ready;
  logic [W_IN-1:0] m_data;
  logic            m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output m_valid, m_data, m_last
  );
endinterface

// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - SOF/LEN/payload/XOR-checksum frame parser with store-and-forward drain
//
// Hunts for SOF, takes a LEN word, buffers LEN payload words, compares the
// trailing checksum word against the XOR of LEN and payload, and only then
// releases the payload on the m_* stream.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus          : uart_rx_framer_if.slave (s_valid/s_data in, m_valid/m_ready/m_data/m_last)
//   busy         : parser is not in IDLE
//   err_len      : one-cycle pulse, LEN word was 0 or above MAX_LEN
//   err_chk      : one-cycle pulse, checksum word mismatched
//   err_overrun  : one-cycle pulse, a word arrived while draining and was dropped
//   err_timeout  : one-cycle pulse, inter-word timeout (constant 0 unless enabled)
//   frame_cnt    : number of frames fully drained, wrapping
// Optional build macro: UART_FRAMER_TIMEOUT_EN enables the inter-word timeout.
module uart_rx_framer #(
  parameter int              W_IN           = 16,
  parameter int              MAX_LEN        = 16,
  parameter logic [W_IN-1:0] SOF            = 16'hA55A,
  parameter int              TIMEOUT_CYCLES = 200000
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_framer_if.slave       bus,
  output logic                  busy,
  output logic                  err_len,
  output logic                  err_chk,
  output logic                  err_overrun,
  output logic                  err_timeout,
  output logic [15:0]           frame_cnt
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHECK,
    S_DRAIN
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   last_idx;   // LEN-1, the index of the final payload word
  logic [IW-1:0]   idx;
  logic [IW-1:0]   rd;
  logic [W_IN-1:0] chk;
  logic [W_IN-1:0] buf_mem [MAX_LEN];

  logic len_ok;
  logic m_valid_i;
  logic m_last_i;
  logic fire;
  logic tmo_hit;
  logic err_len_n, err_chk_n, err_ovr_n;

  assign len_ok    = (bus.s_data != '0) && (bus.s_data <= W_IN'(MAX_LEN));
  assign m_valid_i = (state == S_DRAIN);
  assign m_last_i  = m_valid_i && (rd == last_idx);
  assign fire      = m_valid_i && bus.m_ready;

  assign bus.m_valid = m_valid_i;
  assign bus.m_last  = m_last_i;
  assign bus.m_data  = buf_mem[rd];
  assign busy        = (state != S_IDLE);

`ifdef UART_FRAMER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tmo_cnt;
  logic          tmo_run;

  assign tmo_run = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHECK);
  // A word arriving on the expiry cycle wins, hence the !s_valid term.
  assign tmo_hit = tmo_run && !bus.s_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Restarts on every word and on every state change so each wait is measured fresh.
  always_ff @(posedge clk) begin
    if (rst || !tmo_run || bus.s_valid || (state_n != state)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_tmo_cfg;

  assign tmo_hit        = 1'b0;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_n   = state;
    err_len_n = 1'b0;
    err_chk_n = 1'b0;
    err_ovr_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.s_valid && (bus.s_data == SOF)) state_n = S_LEN;
      end
      S_LEN: begin
        if (bus.s_valid) begin
          if (len_ok) begin
            state_n = S_PAYLOAD;
          end else begin
            err_len_n = 1'b1;
            state_n   = S_IDLE;
          end
        end else if (tmo_hit) begin
          state_n = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (bus.s_valid) begin
          if (idx == last_idx) state_n = S_CHECK;
        end else if (tmo_hit) begin
          state_n = S_IDLE;
        end
      end
      S_CHECK: begin
        if (bus.s_valid) begin
          if (bus.s_data == chk) begin
            state_n = S_DRAIN;
          end else begin
            err_chk_n = 1'b1;
            state_n   = S_IDLE;
          end
        end else if (tmo_hit) begin
          state_n = S_IDLE;
        end
      end
      S_DRAIN: begin
        // Any word here is dropped, even if it coincides with the final handshake.
        err_ovr_n = bus.s_valid;
        if (fire && m_last_i) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      last_idx    <= '0;
      idx         <= '0;
      rd          <= '0;
      chk         <= '0;
      frame_cnt   <= '0;
      err_len     <= 1'b0;
      err_chk     <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      err_len     <= err_len_n;
      err_chk     <= err_chk_n;
      err_overrun <= err_ovr_n;
      err_timeout <= tmo_hit;
      case (state)
        S_LEN: begin
          if (bus.s_valid && len_ok) begin
            // LEN is 1..MAX_LEN here, so LEN-1 fits in IW bits after truncation.
            last_idx <= bus.s_data[IW-1:0] - 1'b1;
            chk      <= bus.s_data;
            idx      <= '0;
          end
        end
        S_PAYLOAD: begin
          if (bus.s_valid) begin
            chk <= chk ^ bus.s_data;
            idx <= idx + 1'b1;
          end
        end
        S_CHECK: begin
          if (bus.s_valid) rd <= '0;
        end
        S_DRAIN: begin
          if (fire) begin
            rd <= rd + 1'b1;
            if (m_last_i) frame_cnt <= frame_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Payload store; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clk) begin
    if ((state == S_PAYLOAD) && bus.s_valid) buf_mem[idx] <= bus.s_data;
  end

endmodule
